voice_mix_sched: RTL and testbench

Per-sample voice scheduler and mixer. On each 48 kHz sample-rate trigger it walks all voice slots in order, starts the shared voice-generator datapath once for every enabled voice, and accumulates the returned samples. After the last slot it emits one saturated mixed sample for the channel. One instance sits between the sample-rate trigger source and each channel's output path, so one generator datapath is time-shared across all voices.

---
 rtl/voice_mix_sched_if.sv | 26 ++
 rtl/voice_mix_sched.sv | 129 ++++++++++++
 tb/tb_voice_mix_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/voice_mix_sched_if.sv
// Generator handshake between the voice scheduler and the shared
// voice-generator datapath.
//   gen_start      scheduler -> generator, one-cycle start pulse
//   gen_voice_idx  scheduler -> generator, slot being serviced
//   gen_done       generator -> scheduler, one-cycle completion pulse
//   gen_smpl       generator -> scheduler, signed sample valid with gen_done
// master: scheduler side; slave: generator side.
interface voice_mix_sched_if #(
  parameter int IDX_W  = 3,
  parameter int SMPL_W = 16
);
  logic                     gen_start;
  logic [IDX_W-1:0]         gen_voice_idx;
  logic                     gen_done;
  logic signed [SMPL_W-1:0] gen_smpl;

  modport master (
    output gen_start, gen_voice_idx,
    input  gen_done, gen_smpl
  );

  modport slave (
    input  gen_start, gen_voice_idx,
    output gen_done, gen_smpl
  );
endinterface

// File: rtl/voice_mix_sched.sv
// Per-sample voice scheduler and mixer. On each sample-rate trigger it
// scans every voice slot in order, launches the shared generator once for
// each enabled slot, accumulates the returned samples and finally emits one
// saturated mix sample.
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   smpl_rate_trig   one-cycle pulse starting a mixing round
//   voice_en         per-slot enable, bit i sampled when slot i is scanned
//   gen              generator handshake (master side)
//   mix_smpl         saturated mix, holds between rounds
//   mix_valid        one-cycle pulse when mix_smpl updates
//   busy             high while a round is in progress
//   overrun          sticky, set by a trigger arriving while busy
module voice_mix_sched #(
  parameter int NVOICES = 8,
  parameter int IDX_W   = 3,
  parameter int SMPL_W  = 16,
  parameter int ACC_W   = SMPL_W + IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     smpl_rate_trig,
  input  logic [NVOICES-1:0]       voice_en,
  voice_mix_sched_if.master        gen,
  output logic signed [SMPL_W-1:0] mix_smpl,
  output logic                     mix_valid,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic [2:0] {IDLE, SCAN, START, WAIT, OUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SMPL_W+1){1'b0}}, {(SMPL_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SMPL_W+1){1'b1}}, {(SMPL_W-1){1'b0}}};

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [SMPL_W-1:0]  r_mix_smpl;
  logic                      r_mix_valid;
  logic                      r_overrun;
  logic                      w_last;
  logic signed [ACC_W-1:0]   w_smpl_ext;
  logic signed [SMPL_W-1:0]  w_sat;

  assign w_last     = (r_idx == IDX_W'(NVOICES - 1));
  assign w_smpl_ext = {{(ACC_W-SMPL_W){gen.gen_smpl[SMPL_W-1]}}, gen.gen_smpl};

  always_comb begin
    w_sat = r_acc[SMPL_W-1:0];
    if (r_acc > SAT_MAX) begin
      w_sat = {1'b0, {(SMPL_W-1){1'b1}}};
    end else if (r_acc < SAT_MIN) begin
      w_sat = {1'b1, {(SMPL_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (smpl_rate_trig) w_state_nxt = SCAN;
      SCAN: begin
        if (voice_en[r_idx])  w_state_nxt = START;
        else if (w_last)      w_state_nxt = OUT;
      end
      START: w_state_nxt = WAIT;
      WAIT:  if (gen.gen_done) w_state_nxt = w_last ? OUT : SCAN;
      OUT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_mix_smpl  <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      // A trigger mid-round is dropped; only the sticky flag records it.
      if (smpl_rate_trig && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (smpl_rate_trig) begin
            r_idx <= '0;
            r_acc <= '0;
          end
        end
        SCAN: begin
          if (!voice_en[r_idx] && !w_last) r_idx <= r_idx + IDX_W'(1);
        end
        WAIT: begin
          if (gen.gen_done) begin
            r_acc <= r_acc + w_smpl_ext;
            if (!w_last) r_idx <= r_idx + IDX_W'(1);
          end
        end
        OUT: begin
          r_mix_smpl  <= w_sat;
          r_mix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gen.gen_start     = (r_state == START);
  assign gen.gen_voice_idx = r_idx;
  assign mix_smpl          = r_mix_smpl;
  assign mix_valid         = r_mix_valid;
  assign busy              = (r_state != IDLE);
  assign overrun           = r_overrun;

endmodule

// File: tb/tb_voice_mix_sched.sv
module tb_voice_mix_sched;
  localparam int NV = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              smpl_rate_trig;
  logic [NV-1:0]     voice_en;
  logic signed [15:0] mix_smpl;
  logic              mix_valid;
  logic              busy;
  logic              overrun;

  voice_mix_sched_if #(.IDX_W(3), .SMPL_W(16)) gif ();

  voice_mix_sched #(.NVOICES(NV), .IDX_W(3), .SMPL_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .smpl_rate_trig (smpl_rate_trig),
    .voice_en       (voice_en),
    .gen            (gif),
    .mix_smpl       (mix_smpl),
    .mix_valid      (mix_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int samp [NV];
  int gen_lat = 1;
  bit spur_mode = 1'b0;
  int n_valid = 0;
  int idx_q[$];
  int mix_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (mix_valid) n_valid <= n_valid + 1;

  // Generator model: answers each start pulse after gen_lat cycles; in
  // spur_mode it also raises gen_done whenever it is not servicing a voice.
  initial begin
    gif.gen_done = 1'b0;
    gif.gen_smpl = '0;
    forever begin
      @(negedge clk);
      gif.gen_done = 1'b0;
      if (gif.gen_start === 1'b1) begin
        int vi;
        vi = int'(gif.gen_voice_idx);
        if (idx_q.size() == 0) chk("gen_start_unexpected", vi, -1);
        else chk("gen_voice_idx", vi, idx_q.pop_front());
        repeat (gen_lat) @(negedge clk);
        gif.gen_done = 1'b1;
        gif.gen_smpl = 16'(samp[vi]);
      end else if (spur_mode) begin
        gif.gen_done = 1'b1;
        gif.gen_smpl = 16'sd1000;
      end
    end
  end

  task automatic run_round(input logic [NV-1:0] en, input int lat, input int extra_trig);
    int sum;
    int ecyc;
    int cyc;
    int exp_mix;
    sum  = 0;
    ecyc = 2;
    for (int i = 0; i < NV; i++) begin
      if (en[i]) begin
        sum  += samp[i];
        ecyc += 2 + lat;
        idx_q.push_back(i);
      end else begin
        ecyc += 1;
      end
    end
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    mix_q.push_back(sum);

    voice_en = en;
    gen_lat  = lat;
    @(negedge clk);
    smpl_rate_trig = 1'b1;
    @(negedge clk);
    smpl_rate_trig = 1'b0;
    cyc = 1;
    chk("busy_in_round", int'(busy), 1);
    while (!mix_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      smpl_rate_trig = (cyc == extra_trig);
    end
    smpl_rate_trig = 1'b0;
    exp_mix = mix_q.pop_front();
    if (!mix_valid) begin
      chk("mix_valid_timeout", 0, 1);
    end else begin
      chk("mix_smpl", int'(mix_smpl), exp_mix);
      chk("mix_latency", cyc, ecyc);
      chk("busy_after", int'(busy), 0);
      @(negedge clk);
      chk("mix_valid_pulse", int'(mix_valid), 0);
      chk("mix_smpl_hold", int'(mix_smpl), exp_mix);
    end
    chk("gen_starts_left", idx_q.size(), 0);
  endtask

  initial begin
    int nv0;
    reset = 1'b1;
    smpl_rate_trig = 1'b0;
    voice_en = '0;
    for (int i = 0; i < NV; i++) samp[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_mix_smpl", int'(mix_smpl), 0);
    chk("rst_mix_valid", int'(mix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_gen_start", int'(gif.gen_start), 0);
    chk("rst_gen_idx", int'(gif.gen_voice_idx), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // all slots disabled
    run_round(8'h00, 1, 0);

    // two voices, minimum latency
    samp[0] = 100; samp[2] = -30;
    run_round(8'h05, 1, 0);

    // positive and negative saturation
    for (int i = 0; i < NV; i++) samp[i] = 32767;
    run_round(8'hFF, 1, 0);
    for (int i = 0; i < NV; i++) samp[i] = -32768;
    run_round(8'hFF, 3, 0);

    // spurious done while idle and scanning
    for (int i = 0; i < NV; i++) samp[i] = 0;
    samp[1] = 5; samp[4] = 7;
    spur_mode = 1'b1;
    repeat (3) @(negedge clk);
    run_round(8'h12, 2, 0);
    spur_mode = 1'b0;

    // second trigger while waiting on the generator
    chk("overrun_before", int'(overrun), 0);
    for (int i = 0; i < NV; i++) samp[i] = i * 100 - 300;
    nv0 = n_valid;
    run_round(8'hFF, 4, 6);
    chk("overrun_set", int'(overrun), 1);
    repeat (40) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);
    chk("no_second_round", n_valid - nv0, 1);
    chk("idle_after_overrun", int'(busy), 0);

    // reset during WAIT of slot 3 (previous mix is nonzero, overrun is set)
    for (int i = 0; i < NV; i++) samp[i] = 50;
    for (int i = 0; i < NV; i++) idx_q.push_back(i);
    gen_lat  = 6;
    voice_en = 8'hFF;
    nv0 = n_valid;
    @(negedge clk);
    smpl_rate_trig = 1'b1;
    @(negedge clk);
    smpl_rate_trig = 1'b0;
    repeat (28) @(negedge clk);
    chk("pre_rst_wait_idx", int'(gif.gen_voice_idx), 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_mix_smpl", int'(mix_smpl), 0);
    chk("mid_rst_mix_valid", int'(mix_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_gen_start", int'(gif.gen_start), 0);
    chk("mid_rst_gen_idx", int'(gif.gen_voice_idx), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    idx_q.delete();
    chk("no_valid_aborted", n_valid - nv0, 0);

    // clean round after reset
    for (int i = 0; i < NV; i++) samp[i] = 0;
    samp[0] = 1234; samp[7] = -234;
    run_round(8'h81, 2, 0);
    chk("overrun_clean", int'(overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
